// File: rtl/i2s_rx_mono24_if.sv
// i2s_rx_mono24_if: I2S pin bundle in, captured mono sample out.
interface i2s_rx_mono24_if #(
  parameter int DATA_W = 24
);
  logic i2s_bclk;
  logic i2s_lrck;
  logic i2s_sdata;
  logic signed [DATA_W-1:0] dout;
  logic dout_valid;
  logic frame_err;
  modport master (
    output i2s_bclk, i2s_lrck, i2s_sdata,
    input  dout, dout_valid, frame_err
  );
  modport slave (
    input  i2s_bclk, i2s_lrck, i2s_sdata,
    output dout, dout_valid, frame_err
  );
endinterface

// File: rtl/i2s_rx_mono24.sv
// i2s_rx_mono24: oversampled Philips I2S receiver emitting one channel as signed DATA_W-bit samples.
module i2s_rx_mono24 #(
  parameter int DATA_W      = 24,
  parameter int CHANNEL     = 0,
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            reset_n,
  i2s_rx_mono24_if.slave bus
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, DONE} state_t;
  state_t                   r_state;
  logic [SYNC_STAGES-1:0]   r_bclk_sync, r_lrck_sync, r_sdata_sync;
  logic                     r_bclk_prev, r_rise, r_lrck_q, r_sdata_q, r_lrck_prev;
  logic [DATA_W-2:0]        r_shift;
  logic [CW-1:0]            r_cnt;
  logic signed [DATA_W-1:0] r_dout;
  logic                     r_valid, r_err;
  logic                     w_edge, w_last;
  logic [DATA_W-1:0]        w_next;
  assign w_edge = r_lrck_q != r_lrck_prev;
  assign w_last = r_cnt == CW'(DATA_W - 1);
  assign w_next = {r_shift, r_sdata_q};
  // lrck/sdata are re-registered alongside r_rise so all three stay aligned
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_bclk_sync  <= '0;
      r_lrck_sync  <= '0;
      r_sdata_sync <= '0;
      r_bclk_prev  <= 1'b0;
      r_rise       <= 1'b0;
      r_lrck_q     <= 1'b0;
      r_sdata_q    <= 1'b0;
      r_lrck_prev  <= 1'b0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_dout       <= '0;
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
      r_state      <= IDLE;
    end else begin
      r_bclk_sync  <= {r_bclk_sync[SYNC_STAGES-2:0], bus.i2s_bclk};
      r_lrck_sync  <= {r_lrck_sync[SYNC_STAGES-2:0], bus.i2s_lrck};
      r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], bus.i2s_sdata};
      r_bclk_prev  <= r_bclk_sync[SYNC_STAGES-1];
      r_rise       <= r_bclk_sync[SYNC_STAGES-1] & ~r_bclk_prev;
      r_lrck_q     <= r_lrck_sync[SYNC_STAGES-1];
      r_sdata_q    <= r_sdata_sync[SYNC_STAGES-1];
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
      if (r_rise) begin
        r_lrck_prev <= r_lrck_q;
        case (r_state)
          IDLE: if (w_edge) r_state <= SKIP;
          // SKIP is entered on the delay-slot bit, so the next bit is the MSB
          SKIP:
            if (w_edge) r_err <= 1'b1;
            else begin
              r_shift <= w_next[DATA_W-2:0];
              r_cnt   <= CW'(1);
              r_state <= SHIFT;
            end
          SHIFT:
            if (w_edge) begin
              r_err   <= 1'b1;
              r_state <= SKIP;
            end else begin
              r_shift <= w_next[DATA_W-2:0];
              r_cnt   <= r_cnt + 1'b1;
              if (w_last) begin
                r_state <= DONE;
                if (r_lrck_q == CHANNEL[0]) begin
                  r_dout  <= w_next;
                  r_valid <= 1'b1;
                end
              end
            end
          DONE: if (w_edge) r_state <= SKIP;
        endcase
      end
    end
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_valid;
  assign bus.frame_err  = r_err;
endmodule

// File: tb/tb_i2s_rx_mono24.sv
// tb_i2s_rx_mono24: drives one I2S stream into a left-channel and a right-channel receiver
// and checks both every cycle against a bit-index model of the framing rules.
module tb_i2s_rx_mono24;
  localparam int W = 24;
  typedef struct { int due; logic [W-1:0] w; } ev_t;
  logic clk = 0, reset_n = 0, bclk = 0, lrck = 0, sdata = 0;
  int cyc = 0, ratio = 8, n_cmp = 0, n_bad = 0, lsb_cyc = 0, rise_cyc = 0;
  ev_t vq[2][$];
  int eq[2][$];
  logic [W-1:0] exp_dout[2];
  int cnt_v[2], cnt_e[2], last_v[2];
  logic m_prev = 0, m_cap = 0, xv, xe;
  int m_idx = 0;
  logic [W-1:0] m_word = '0;
  logic [1:0] o_v, o_e;
  logic [W-1:0] o_d[2];

  i2s_rx_mono24_if #(.DATA_W(W)) bus0 ();
  i2s_rx_mono24_if #(.DATA_W(W)) bus1 ();
  assign bus0.i2s_bclk = bclk;
  assign bus0.i2s_lrck = lrck;
  assign bus0.i2s_sdata = sdata;
  assign bus1.i2s_bclk = bclk;
  assign bus1.i2s_lrck = lrck;
  assign bus1.i2s_sdata = sdata;
  assign o_v = {bus1.dout_valid, bus0.dout_valid};
  assign o_e = {bus1.frame_err, bus0.frame_err};
  assign o_d[0] = bus0.dout;
  assign o_d[1] = bus1.dout;

  i2s_rx_mono24 #(.DATA_W(W), .CHANNEL(0), .SYNC_STAGES(2)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  i2s_rx_mono24 #(.DATA_W(W), .CHANNEL(1), .SYNC_STAGES(2)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Every cycle: valid/err must fire exactly on the predicted cycle, dout must hold the last word
  always @(negedge clk)
    for (int c = 0; c < 2; c++) begin
      xv = vq[c].size() > 0 && vq[c][0].due == cyc;
      xe = eq[c].size() > 0 && eq[c][0] == cyc;
      if (xv) begin
        exp_dout[c] = vq[c][0].w;
        void'(vq[c].pop_front());
      end
      if (xe) void'(eq[c].pop_front());
      if (o_v[c]) begin
        cnt_v[c]++;
        last_v[c] = cyc;
      end
      if (o_e[c]) cnt_e[c]++;
      cmp($sformatf("dout_valid%0d", c), o_v[c], xv);
      cmp($sformatf("frame_err%0d", c), o_e[c], xe);
      cmp($sformatf("dout%0d", c), o_d[c], exp_dout[c]);
    end

  // Bit-index view of the stream: an lrck change starts a word, indices 1..W carry it MSB first
  task automatic model(input logic lr, input logic sd, input int t);
    if (lr != m_prev) begin
      if (m_cap) begin
        eq[0].push_back(t + 4);
        eq[1].push_back(t + 4);
      end
      m_cap = 1;
      m_idx = 0;
    end else if (m_cap) begin
      m_idx++;
      m_word = {m_word[W-2:0], sd};
      if (m_idx == W) begin
        vq[int'(lr)].push_back('{t + 4, m_word});
        m_cap = 0;
      end
    end
    m_prev = lr;
  endtask

  task automatic send_bit(input logic lr, input logic sd);
    @(negedge clk);
    bclk = 0;
    lrck = lr;
    sdata = sd;
    repeat (ratio / 2) @(negedge clk);
    bclk = 1;
    rise_cyc = cyc;
    model(lr, sd, cyc);
    repeat (ratio / 2 - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bclk = 0;
    #2 reset_n = 0;
    m_prev = 0;
    m_cap = 0;
    for (int c = 0; c < 2; c++) begin
      vq[c].delete();
      eq[c].delete();
      exp_dout[c] = '0;
    end
    repeat (3) @(negedge clk);
    reset_n = 1;
  endtask

  task automatic send_half(input logic lr, input logic [W-1:0] w, input int n, input int rst_at);
    logic sd;
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) do_reset();
      sd = (i >= 1 && i <= W) ? w[W-i] : 1'($urandom_range(0, 1));
      send_bit(lr, sd);
      if (i == W && lr == 1'b0) lsb_cyc = rise_cyc;
    end
  endtask

  initial begin
    int b0, b1, be;
    logic [W-1:0] lw;
    exp_dout[0] = '0;
    exp_dout[1] = '0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    cmp("reset dout0", o_d[0], 0);
    cmp("reset dout1", o_d[1], 0);
    cmp("reset valid", o_v, 0);
    cmp("reset err", o_e, 0);
    // Full 32-bit slots, fixed words
    b0 = cnt_v[0]; b1 = cnt_v[1]; be = cnt_e[0];
    send_half(1, 24'h5A5A5A, 32, -1);
    repeat (3) begin
      send_half(0, 24'h7FFFFF, 32, -1);
      send_half(1, 24'h123456, 32, -1);
    end
    cmp("t1 dout0", o_d[0], 24'h7FFFFF);
    cmp("t1 dout1", o_d[1], 24'h123456);
    cmp("t1 nvalid0", cnt_v[0] - b0, 3);
    cmp("t1 nvalid1", cnt_v[1] - b1, 4);
    cmp("t1 nerr", cnt_e[0] - be, 0);
    // Most negative word and pin-to-valid latency
    send_half(0, 24'h800000, 32, -1);
    send_half(1, 24'h123456, 32, -1);
    cmp("t2 dout0", o_d[0], 24'h800000);
    cmp("t2 latency", last_v[0] - lsb_cyc, 4);
    // Short 16-bit halves: every edge after the first interrupts a word
    b0 = cnt_v[0]; b1 = cnt_v[1]; be = cnt_e[0];
    repeat (3) begin
      send_half(0, 24'($urandom), 16, -1);
      send_half(1, 24'($urandom), 16, -1);
    end
    cmp("t3 hold dout0", o_d[0], 24'h800000);
    cmp("t3 nvalid0", cnt_v[0] - b0, 0);
    cmp("t3 nvalid1", cnt_v[1] - b1, 0);
    send_half(0, 24'hABCDEF, 32, -1);
    cmp("t3 nerr0", cnt_e[0] - be, 6);
    cmp("t3 dout0", o_d[0], 24'hABCDEF);
    // Reset in the middle of a left word
    b0 = cnt_v[0]; b1 = cnt_v[1]; be = cnt_e[0];
    send_half(1, 24'h0F0F0F, 32, -1);
    send_half(0, 24'h111111, 32, 10);
    cmp("t4 dout0 after reset", o_d[0], 0);
    cmp("t4 dout1 after reset", o_d[1], 0);
    send_half(1, 24'h2468AC, 32, -1);
    send_half(0, 24'h13579B, 32, -1);
    cmp("t4 dout0", o_d[0], 24'h13579B);
    cmp("t4 dout1", o_d[1], 24'h2468AC);
    cmp("t4 nvalid0", cnt_v[0] - b0, 1);
    cmp("t4 nvalid1", cnt_v[1] - b1, 2);
    cmp("t4 nerr", cnt_e[0] - be, 0);
    // Minimum clk/bclk ratio, random words
    ratio = 4;
    b0 = cnt_v[0]; b1 = cnt_v[1]; be = cnt_e[0];
    lw = '0;
    send_half(1, 24'($urandom), 32, -1);
    repeat (100) begin
      lw = 24'($urandom);
      send_half(0, lw, 32, -1);
      send_half(1, 24'($urandom), 32, -1);
    end
    cmp("t5 nvalid0", cnt_v[0] - b0, 100);
    cmp("t5 nvalid1", cnt_v[1] - b1, 101);
    cmp("t5 nerr", cnt_e[0] - be, 0);
    cmp("t5 last dout0", o_d[0], lw);
    repeat (8) @(negedge clk);
    cmp("pending events0", vq[0].size() + eq[0].size(), 0);
    cmp("pending events1", vq[1].size() + eq[1].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
